eta_scheduler: RTL and testbench

Training-run sequencer that drives the DNN's per-sample inputs from the block-cycle domain. Once per `cycle_clk` it issues a sample address to the training-data store and the matching learning rate on `eta_in`. It applies a per-epoch multiplicative decay to that rate. When the run ends it keeps feeding eta = 0 until the L-stage pipeline has drained, so bubble slots never update weights.

---
 rtl/dnn_pkg.sv | 15 +
 rtl/eta_decay.sv | 22 ++
 rtl/eta_scheduler.sv | 139 +++++++++++++
 tb/tb_eta_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN training blocks: scheduler state encoding
// and the fixed-point constant for eta = 1.0.
package dnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } eta_sched_state_t;

  localparam int FRAC_BITS = 10;
  localparam int ETA_ONE   = 1 << FRAC_BITS;

endpackage

// File: rtl/eta_decay.sv
// Combinational per-epoch learning-rate decay: eta - (eta >> shift), floored
// at eta_min with an unsigned compare so the rate never collapses to zero.
module eta_decay #(
  parameter int               width       = 16,
  parameter int               decay_shift = 3,
  parameter logic [width-1:0] eta_min     = 16'h0001
) (
  input  logic [width-1:0] i_eta,
  output logic [width-1:0] o_eta
);

  logic [width-1:0] w_shifted;
  logic [width-1:0] w_diff;

  // Logical shift keeps the subtrahend <= i_eta, so the difference cannot wrap.
  always_comb begin
    w_shifted = i_eta >> decay_shift;
    w_diff    = i_eta - w_shifted;
    o_eta     = (w_diff < eta_min) ? eta_min : w_diff;
  end

endmodule

// File: rtl/eta_scheduler.sv
// Training-run sequencer: streams sample addresses with a per-epoch decayed
// learning rate, then feeds eta = 0 for L+1 cycles so the pipeline drains.
module eta_scheduler
  import dnn_pkg::*;
#(
  parameter int               width       = 16,
  parameter int               frac_bits   = 10,
  parameter int               num_samples = 1024,
  parameter int               num_epochs  = 4,
  parameter logic [width-1:0] eta_init    = width'(1 << frac_bits),
  parameter int               decay_shift = 3,
  parameter logic [width-1:0] eta_min     = 16'h0001,
  parameter int               L           = 3
) (
  input  logic                               cycle_clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               pause,
  output logic [width-1:0]                   eta_in,
  output logic [$clog2(num_samples)-1:0]     sample_addr,
  output logic                               sample_valid,
  output logic [$clog2(num_epochs+1)-1:0]    epoch,
  output logic                               busy,
  output logic                               done,
  output eta_sched_state_t                   dbg_state
);

  localparam int AW = $clog2(num_samples);
  localparam int EW = $clog2(num_epochs + 1);
  localparam int DW = (L > 0) ? $clog2(L + 1) : 1;

  eta_sched_state_t r_state;
  eta_sched_state_t w_next_state;

  logic [AW-1:0]    r_addr;
  logic [EW-1:0]    r_epoch;
  logic [width-1:0] r_eta;
  logic [DW-1:0]    r_drain_cnt;
  logic [width-1:0] w_eta_decayed;
  logic             w_last_addr;
  logic             w_last_epoch;
  logic             w_drain_last;

  eta_decay #(
    .width       (width),
    .decay_shift (decay_shift),
    .eta_min     (eta_min)
  ) u_eta_decay (
    .i_eta (r_eta),
    .o_eta (w_eta_decayed)
  );

  assign w_last_addr  = (r_addr == AW'(num_samples - 1));
  assign w_last_epoch = (r_epoch == EW'(num_epochs - 1));
  assign w_drain_last = (r_drain_cnt == DW'(L));
  assign dbg_state    = r_state;

  always_ff @(posedge cycle_clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_RUN;
      ST_RUN:   if (!pause && w_last_addr && w_last_epoch) w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_drain_last) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Outputs describe the action the pre-edge state takes on this edge:
  // sample_valid=1 means sample_addr/eta_in name a real sample for exactly
  // this cycle; there is no back-pressure, the consumer must take it.
  always_ff @(posedge cycle_clk) begin
    if (!reset) begin
      r_addr       <= '0;
      r_epoch      <= '0;
      r_eta        <= eta_init;
      r_drain_cnt  <= '0;
      eta_in       <= '0;
      sample_addr  <= '0;
      sample_valid <= 1'b0;
      epoch        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      eta_in       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_addr      <= '0;
          r_epoch     <= '0;
          r_drain_cnt <= '0;
          r_eta       <= eta_init;
          sample_addr <= '0;
          epoch       <= '0;
        end
        ST_RUN: begin
          busy <= 1'b1;
          if (!pause) begin
            sample_valid <= 1'b1;
            eta_in       <= r_eta;
            sample_addr  <= r_addr;
            epoch        <= r_epoch;
            if (w_last_addr) begin
              r_addr <= '0;
              if (!w_last_epoch) begin
                r_epoch <= r_epoch + 1'b1;
                r_eta   <= w_eta_decayed;
              end
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          busy        <= 1'b1;
          r_drain_cnt <= r_drain_cnt + 1'b1;
        end
        ST_DONE: begin
          done  <= 1'b1;
          r_eta <= eta_init;
        end
        default: begin
          r_eta <= eta_init;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eta_scheduler.sv
// Directed bench for eta_scheduler: small N/E configurations with hand-derived
// address, eta, epoch and done timing.
module tb_eta_scheduler;
  import dnn_pkg::*;

  logic cycle_clk;
  logic reset;
  logic start_a;
  logic start_b;
  logic pause;

  logic [15:0]      eta_a, eta_b;
  logic [1:0]       addr_a, addr_b;
  logic             valid_a, valid_b;
  logic [1:0]       epoch_a, epoch_b;
  logic             busy_a, busy_b;
  logic             done_a, done_b;
  eta_sched_state_t state_a, state_b;

  int n_checks;
  int n_pass;

  eta_scheduler #(
    .width(16), .frac_bits(10), .num_samples(4), .num_epochs(2),
    .eta_init(16'h0400), .decay_shift(1), .eta_min(16'h0001), .L(3)
  ) dut_a (
    .cycle_clk(cycle_clk), .reset(reset), .start(start_a), .pause(pause),
    .eta_in(eta_a), .sample_addr(addr_a), .sample_valid(valid_a),
    .epoch(epoch_a), .busy(busy_a), .done(done_a), .dbg_state(state_a)
  );

  eta_scheduler #(
    .width(16), .frac_bits(10), .num_samples(4), .num_epochs(3),
    .eta_init(16'h0002), .decay_shift(1), .eta_min(16'h0001), .L(3)
  ) dut_b (
    .cycle_clk(cycle_clk), .reset(reset), .start(start_b), .pause(1'b0),
    .eta_in(eta_b), .sample_addr(addr_b), .sample_valid(valid_b),
    .epoch(epoch_b), .busy(busy_b), .done(done_b), .dbg_state(state_b)
  );

  initial cycle_clk = 1'b0;
  always #5 cycle_clk = ~cycle_clk;

  task automatic tick;
    @(posedge cycle_clk);
    #1;
  endtask

  task automatic start_run_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // Edges until done_a is seen, -1 if it never comes within the budget.
  task automatic wait_done_a(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done_a === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; pause = 1'b0;
    tick();
    tick();
    n_checks++; if (eta_a !== 16'h0) $display("FAIL reset_eta got %h exp 0000", eta_a); else n_pass++;
    n_checks++; if (addr_a !== 2'd0) $display("FAIL reset_addr got %0d exp 0", addr_a); else n_pass++;
    n_checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_a); else n_pass++;
    n_checks++; if (epoch_a !== 2'd0) $display("FAIL reset_epoch got %0d exp 0", epoch_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done got %b exp 0", done_a); else n_pass++;
    n_checks++; if (state_a !== ST_IDLE) $display("FAIL reset_state got %0d exp 0", state_a); else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_run;
    logic [15:0] exp_eta;
    int n;
    start_run_a();
    n_checks++; if (valid_a !== 1'b0) $display("FAIL basic_first_edge_valid got %b exp 0", valid_a); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_eta = (i < 4) ? 16'h0400 : 16'h0200;
      n_checks++; if (valid_a !== 1'b1) $display("FAIL basic_valid[%0d] got %b exp 1", i, valid_a); else n_pass++;
      n_checks++; if (addr_a !== 2'(i % 4)) $display("FAIL basic_addr[%0d] got %0d exp %0d", i, addr_a, i % 4); else n_pass++;
      n_checks++; if (eta_a !== exp_eta) $display("FAIL basic_eta[%0d] got %h exp %h", i, eta_a, exp_eta); else n_pass++;
      n_checks++; if (epoch_a !== 2'(i / 4)) $display("FAIL basic_epoch[%0d] got %0d exp %0d", i, epoch_a, i / 4); else n_pass++;
      n_checks++; if (busy_a !== 1'b1) $display("FAIL basic_busy[%0d] got %b exp 1", i, busy_a); else n_pass++;
    end
    for (int d = 0; d < 4; d++) begin
      tick();
      n_checks++; if (valid_a !== 1'b0 || eta_a !== 16'h0) $display("FAIL drain[%0d] valid %b eta %h exp 0 0000", d, valid_a, eta_a); else n_pass++;
      n_checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) $display("FAIL drain_busy[%0d] busy %b done %b exp 1 0", d, busy_a, done_a); else n_pass++;
    end
    tick();
    n_checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL done_pulse done %b busy %b exp 1 0", done_a, busy_a); else n_pass++;
    tick();
    n_checks++; if (done_a !== 1'b0 || valid_a !== 1'b0) $display("FAIL after_done done %b valid %b exp 0 0", done_a, valid_a); else n_pass++;
    n_checks++; if (state_a !== ST_IDLE) $display("FAIL after_done_state got %0d exp 0", state_a); else n_pass++;
    n = 0;
  endtask

  task automatic test_floor;
    logic [15:0] exp_eta;
    int n;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_eta = (i < 4) ? 16'h0002 : 16'h0001;
      n_checks++; if (valid_b !== 1'b1) $display("FAIL floor_valid[%0d] got %b exp 1", i, valid_b); else n_pass++;
      n_checks++; if (eta_b !== exp_eta) $display("FAIL floor_eta[%0d] got %h exp %h", i, eta_b, exp_eta); else n_pass++;
    end
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done_b === 1'b1) begin
        n = i;
        break;
      end
    end
    n_checks++; if (n !== 5) $display("FAIL floor_done_delay got %0d exp 5", n); else n_pass++;
    tick();
  endtask

  task automatic test_pause;
    int n;
    start_run_a();
    tick(); tick(); tick();
    n_checks++; if (addr_a !== 2'd2 || valid_a !== 1'b1) $display("FAIL pause_pre addr %0d valid %b exp 2 1", addr_a, valid_a); else n_pass++;
    pause = 1'b1;
    for (int p = 0; p < 2; p++) begin
      tick();
      n_checks++; if (valid_a !== 1'b0 || eta_a !== 16'h0) $display("FAIL pause_bubble[%0d] valid %b eta %h exp 0 0000", p, valid_a, eta_a); else n_pass++;
      n_checks++; if (addr_a !== 2'd2 || busy_a !== 1'b1) $display("FAIL pause_hold[%0d] addr %0d busy %b exp 2 1", p, addr_a, busy_a); else n_pass++;
    end
    pause = 1'b0;
    tick();
    n_checks++; if (addr_a !== 2'd3 || valid_a !== 1'b1 || eta_a !== 16'h0400) $display("FAIL pause_resume addr %0d valid %b eta %h exp 3 1 0400", addr_a, valid_a, eta_a); else n_pass++;
    wait_done_a(n);
    n_checks++; if (n !== 9) $display("FAIL pause_done_delay got %0d exp 9", n); else n_pass++;
    tick();
  endtask

  task automatic test_start_while_busy;
    int n;
    start_run_a();
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      start_a = (i == 3 || i == 10);
      tick();
      if (done_a === 1'b1) begin
        n = i;
        break;
      end
    end
    start_a = 1'b0;
    n_checks++; if (n !== 13) $display("FAIL busy_start_done_delay got %0d exp 13", n); else n_pass++;
    tick();
    n_checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0) $display("FAIL busy_start_idle busy %b valid %b exp 0 0", busy_a, valid_a); else n_pass++;
    tick();
    n_checks++; if (state_a !== ST_IDLE) $display("FAIL busy_start_state got %0d exp 0", state_a); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int n;
    start_run_a();
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (epoch_a !== 2'd1 || addr_a !== 2'd1 || eta_a !== 16'h0200) $display("FAIL mid_pre epoch %0d addr %0d eta %h exp 1 1 0200", epoch_a, addr_a, eta_a); else n_pass++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++; if (eta_a !== 16'h0 || addr_a !== 2'd0 || valid_a !== 1'b0) $display("FAIL mid_reset_out eta %h addr %0d valid %b exp 0000 0 0", eta_a, addr_a, valid_a); else n_pass++;
    n_checks++; if (epoch_a !== 2'd0 || busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL mid_reset_ctl epoch %0d busy %b done %b exp 0 0 0", epoch_a, busy_a, done_a); else n_pass++;
    start_run_a();
    tick();
    n_checks++; if (addr_a !== 2'd0 || eta_a !== 16'h0400 || epoch_a !== 2'd0 || valid_a !== 1'b1) $display("FAIL mid_restart addr %0d eta %h epoch %0d valid %b exp 0 0400 0 1", addr_a, eta_a, epoch_a, valid_a); else n_pass++;
    wait_done_a(n);
    n_checks++; if (n !== 12) $display("FAIL mid_restart_done got %0d exp 12", n); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back;
    int n;
    start_a = 1'b1;
    tick();
    wait_done_a(n);
    n_checks++; if (n !== 13) $display("FAIL b2b_done1 got %0d exp 13", n); else n_pass++;
    tick();
    n_checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL b2b_gap1 valid %b busy %b done %b exp 0 0 0", valid_a, busy_a, done_a); else n_pass++;
    tick();
    n_checks++; if (valid_a !== 1'b1 || addr_a !== 2'd0 || eta_a !== 16'h0400 || epoch_a !== 2'd0) $display("FAIL b2b_run2 valid %b addr %0d eta %h epoch %0d exp 1 0 0400 0", valid_a, addr_a, eta_a, epoch_a); else n_pass++;
    wait_done_a(n);
    n_checks++; if (n !== 12) $display("FAIL b2b_done2 got %0d exp 12", n); else n_pass++;
    tick();
    n_checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL b2b_gap2 valid %b busy %b exp 0 0", valid_a, busy_a); else n_pass++;
    start_a = 1'b0;
    tick();
    n_checks++; if (valid_a !== 1'b1 || addr_a !== 2'd0 || eta_a !== 16'h0400) $display("FAIL b2b_run3 valid %b addr %0d eta %h exp 1 0 0400", valid_a, addr_a, eta_a); else n_pass++;
    wait_done_a(n);
    n_checks++; if (n !== 12) $display("FAIL b2b_done3 got %0d exp 12", n); else n_pass++;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    pause    = 1'b0;
    test_reset();
    test_basic_run();
    test_floor();
    test_pause();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
